// File: rtl/pipe_pkg.sv
// Shared definitions for Mini-MIPS pipeline stage registers: default field
// widths, the canonical MIPS NOP encoding used for bubbles, the default-width
// payload layout, and the per-cycle operation decode shared by every stage.
package pipe_pkg;

   localparam int DEFAULT_INSTR_W = 32;
   localparam int DEFAULT_PC_W    = 32;

   // sll $0,$0,0 encodes as all zeros
   localparam logic [31:0] MIPS_NOP_INSTR = 32'h0000_0000;

   // Payload layout carried across a stage boundary (instruction in the upper
   // bits, PC in the lower bits); stages with other widths mirror this order
   typedef struct packed {
      logic [DEFAULT_INSTR_W-1:0] instruction;
      logic [DEFAULT_PC_W-1:0]    pc;
   } payload_t;

   // What the stage does this cycle, after reset has been excluded
   typedef enum logic [1:0] {
      STAGE_RUN   = 2'd0,
      STAGE_STALL = 2'd1,
      STAGE_FLUSH = 2'd2
   } stageOp_e;

   // Flush outranks stall; with neither, the normal handshake runs
   function automatic stageOp_e decodeStageOp(input logic flushIn, input logic stallIn);
      stageOp_e op;
      if (flushIn) begin
         op = STAGE_FLUSH;
      end else if (stallIn) begin
         op = STAGE_STALL;
      end else begin
         op = STAGE_RUN;
      end
      return op;
   endfunction

endpackage

// File: rtl/pipeline_skid_slot.sv
// Single-entry skid slot: one payload word plus an occupancy flag. The owning
// stage parks a word here while its output register is blocked and pulls it
// back out on the next downstream transfer. Clear wins over load, load over
// unload.
module pipeline_skid_slot #(
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_i,
   input  logic              unload_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o
);

   logic              full_q;
   logic [DATA_W-1:0] data_q;

   // Occupancy flag and stored word; the word is only captured on a load
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (clear_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         full_q <= 1'b1;
         data_q <= data_i;
      end else if (unload_i) begin
         full_q <= 1'b0;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Handshaked pipeline stage register (instruction + PC + valid) for any
// Mini-MIPS stage boundary. Supports hazard stall, branch flush with NOP
// bubble insertion, valid/ready back-pressure and a saturating stall-cycle
// counter. Define PIPE_SKID_EN to add a one-word skid slot, which makes
// in_ready independent of out_ready while keeping full throughput.
module pipeline_stage_reg
   import pipe_pkg::*;
#(
   parameter int                 INSTR_W   = DEFAULT_INSTR_W,
   parameter int                 PC_W      = DEFAULT_PC_W,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(MIPS_NOP_INSTR),
   parameter int                 CNT_W     = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instruction,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               stall,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instruction,
   output logic [PC_W-1:0]    out_pc,
   output logic [CNT_W-1:0]   stall_count
);

   // Same field order as pipe_pkg::payload_t, sized by this instance
   typedef struct packed {
      logic [INSTR_W-1:0] instruction;
      logic [PC_W-1:0]    pc;
   } stagePayload_t;

   stageOp_e         stageOp;
   stagePayload_t    inPayload;
   stagePayload_t    outPayload_q;
   stagePayload_t    outPayload_d;
   logic             outValid_q;
   logic             outValid_d;
   logic             inReady;
   logic             xferIn;
   logic             xferOut;
   logic             stallQualify;
   logic [CNT_W-1:0] stallCount_q;
   logic [CNT_W-1:0] stallCount_d;

   assign stageOp   = decodeStageOp(flush, stall);
   assign inPayload = '{instruction: in_instruction, pc: in_pc};
   assign xferIn    = in_valid & inReady;
   assign xferOut   = outValid_q & out_ready;

`ifdef PIPE_SKID_EN
   logic                    skidFull;
   logic                    skidLoad;
   logic                    skidUnload;
   logic                    skidClear;
   logic [INSTR_W+PC_W-1:0] skidData;
   stagePayload_t           skidPayload;

   assign skidPayload = stagePayload_t'(skidData);

   // Ready depends only on flops plus stall/flush, so out_ready never
   // reaches in_ready combinationally
   assign inReady = ~reset & ~skidFull & (stageOp == STAGE_RUN);

   pipeline_skid_slot #(
      .DATA_W(INSTR_W + PC_W)
   ) u_skidSlot (
      .clock    (clock),
      .reset    (reset),
      .load_i   (skidLoad),
      .unload_i (skidUnload),
      .clear_i  (skidClear),
      .data_i   (inPayload),
      .data_o   (skidData),
      .full_o   (skidFull)
   );

   // Output-register next state with the skid: a word accepted while the
   // output is blocked parks in the skid and is promoted ahead of any new
   // input on the next drain, which keeps words in order
   always_comb begin
      outValid_d   = outValid_q;
      outPayload_d = outPayload_q;
      skidLoad     = 1'b0;
      skidUnload   = 1'b0;
      skidClear    = 1'b0;
      case (stageOp)
         STAGE_FLUSH: begin
            outValid_d               = 1'b0;
            outPayload_d.instruction = NOP_INSTR;
            skidClear                = 1'b1;
         end
         STAGE_STALL: begin
            if (out_ready) begin
               if (skidFull) begin
                  outValid_d   = 1'b1;
                  outPayload_d = skidPayload;
                  skidUnload   = 1'b1;
               end else begin
                  outValid_d               = 1'b0;
                  outPayload_d.instruction = NOP_INSTR;
               end
            end
         end
         default: begin
            if (outValid_q & ~out_ready) begin
               skidLoad = xferIn;
            end else if (skidFull) begin
               outValid_d   = 1'b1;
               outPayload_d = skidPayload;
               skidUnload   = 1'b1;
            end else if (xferIn) begin
               outValid_d   = 1'b1;
               outPayload_d = inPayload;
            end else if (xferOut) begin
               outValid_d               = 1'b0;
               outPayload_d.instruction = NOP_INSTR;
            end
         end
      endcase
   end
`else
   // Accept when the output register is empty or being drained this cycle
   assign inReady = ~reset & (stageOp == STAGE_RUN) & (~outValid_q | out_ready);

   // Output-register next state for the single-register stage: load on a
   // transfer in, turn into a NOP bubble when drained with nothing behind it
   always_comb begin
      outValid_d   = outValid_q;
      outPayload_d = outPayload_q;
      case (stageOp)
         STAGE_FLUSH: begin
            outValid_d               = 1'b0;
            outPayload_d.instruction = NOP_INSTR;
         end
         STAGE_STALL: begin
            if (out_ready) begin
               outValid_d               = 1'b0;
               outPayload_d.instruction = NOP_INSTR;
            end
         end
         default: begin
            if (xferIn) begin
               outValid_d   = 1'b1;
               outPayload_d = inPayload;
            end else if (xferOut) begin
               outValid_d               = 1'b0;
               outPayload_d.instruction = NOP_INSTR;
            end
         end
      endcase
   end
`endif

   // A stalled cycle is an offered word that is refused for any reason other
   // than a flush; the counter sticks at all-ones
   assign stallQualify = in_valid & ~inReady & ~flush;

   // Saturating increment of the stall-cycle counter
   always_comb begin
      stallCount_d = stallCount_q;
      if (stallQualify && (stallCount_q != {CNT_W{1'b1}})) begin
         stallCount_d = stallCount_q + CNT_W'(1);
      end
   end

   // Stage state: output register, valid bit and stall counter; reset
   // presents an empty stage carrying a NOP at PC 0
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outValid_q   <= 1'b0;
         outPayload_q <= '{instruction: NOP_INSTR, pc: '0};
         stallCount_q <= '0;
      end else begin
         outValid_q   <= outValid_d;
         outPayload_q <= outPayload_d;
         stallCount_q <= stallCount_d;
      end
   end

   assign in_ready        = inReady;
   assign out_valid       = outValid_q;
   assign out_instruction = outPayload_q.instruction;
   assign out_pc          = outPayload_q.pc;
   assign stall_count     = stallCount_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg: directed vector table, a
// back-pressure sequence, randomized traffic against a word-queue model,
// asynchronous reset mid-run and stall-counter saturation (CNT_W = 4).
module tb_pipeline_stage_reg;

   localparam int          CNT_W   = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [31:0] NOP     = 32'h0000_0000;

`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
   int bpRdy[7] = '{1, 1, 0, 0, 1, 1, 1};
   int bpCnt[7] = '{3, 3, 4, 5, 5, 5, 5};
`else
   localparam bit SKID = 1'b0;
   int bpRdy[7] = '{1, 0, 0, 1, 1, 1, 1};
   int bpCnt[7] = '{3, 4, 5, 5, 5, 5, 5};
`endif
   int bpOrdy[7]  = '{1, 0, 0, 1, 1, 1, 1};
   int bpOutIdx[7] = '{0, 0, 0, 1, 2, 3, 3};
   int bpValid[7] = '{1, 1, 1, 1, 1, 1, 0};

   logic             clock = 1'b0;
   logic             reset;
   logic             inValid;
   logic             inReady;
   logic [31:0]      inInstruction;
   logic [31:0]      inPc;
   logic             stall;
   logic             flush;
   logic             outValid;
   logic             outReady;
   logic [31:0]      outInstruction;
   logic [31:0]      outPc;
   logic [CNT_W-1:0] stallCount;

   int errorCount = 0;
   int checkCount = 0;

   typedef struct {
      logic        iv;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        st;
      logic        fl;
      logic        ordy;
      logic        expRdy;
      logic        expValid;
      logic [31:0] expInstr;
      logic [31:0] expPc;
      int          expCount;
   } vector_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } word_t;

   vector_t     vectors[12];
   word_t       bpWords[4];
   word_t       modelQ[$];
   logic [31:0] modelLastPc;
   int          modelCount;

   pipeline_stage_reg #(
      .INSTR_W   (32),
      .PC_W      (32),
      .NOP_INSTR (32'h0000_0000),
      .CNT_W     (CNT_W)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .in_valid        (inValid),
      .in_ready        (inReady),
      .in_instruction  (inInstruction),
      .in_pc           (inPc),
      .stall           (stall),
      .flush           (flush),
      .out_valid       (outValid),
      .out_ready       (outReady),
      .out_instruction (outInstruction),
      .out_pc          (outPc),
      .stall_count     (stallCount)
   );

   // 10-unit clock period
   always #5 clock = ~clock;

   task automatic applyStimulus(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                                input logic st, input logic fl, input logic ordy);
      inValid       = iv;
      inInstruction = instr;
      inPc          = pc;
      stall         = st;
      flush         = fl;
      outReady      = ordy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic expValid, input logic [31:0] expInstr,
                             input logic [31:0] expPc, input int expCount);
      checkOutput({tag, " out_valid"}, 32'(outValid), 32'(expValid));
      checkOutput({tag, " out_instruction"}, outInstruction, expInstr);
      checkOutput({tag, " out_pc"}, outPc, expPc);
      checkOutput({tag, " stall_count"}, 32'(stallCount), 32'(expCount));
   endtask

   // One randomized cycle checked against the word-queue model: the stage
   // holds up to one word (two with the skid) in arrival order
   task automatic randomCycle(input int n);
      logic        iv;
      logic        st;
      logic        fl;
      logic        ordy;
      logic        expRdy;
      logic [31:0] expInstr;
      word_t       w;
      iv      = ($urandom_range(0, 3) != 0);
      st      = ($urandom_range(0, 4) == 0);
      fl      = ($urandom_range(0, 11) == 0);
      ordy    = ($urandom_range(0, 2) != 0);
      w.instr = $urandom;
      w.pc    = $urandom;
      applyStimulus(iv, w.instr, w.pc, st, fl, ordy);
      #1;
      if (SKID) begin
         expRdy = !st && !fl && (modelQ.size() < 2);
      end else begin
         expRdy = !st && !fl && ((modelQ.size() == 0) || ordy);
      end
      checkOutput($sformatf("rand%0d in_ready", n), 32'(inReady), 32'(expRdy));
      if (iv && !expRdy && !fl && (modelCount < CNT_MAX)) begin
         modelCount++;
      end
      if (fl) begin
         modelQ.delete();
      end else begin
         if ((modelQ.size() > 0) && ordy) begin
            void'(modelQ.pop_front());
         end
         if (iv && expRdy) begin
            modelQ.push_back(w);
         end
      end
      @(posedge clock);
      #1;
      if (modelQ.size() > 0) begin
         modelLastPc = modelQ[0].pc;
         expInstr    = modelQ[0].instr;
      end else begin
         expInstr = NOP;
      end
      checkState($sformatf("rand%0d", n), (modelQ.size() > 0), expInstr, modelLastPc, modelCount);
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      vectors[0]  = '{1'b1, 32'h2008_0005, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2008_0005, 32'h00, 0};
      vectors[1]  = '{1'b1, 32'h2009_0003, 32'h04, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2009_0003, 32'h04, 0};
      vectors[2]  = '{1'b1, 32'h2010_AAAA, 32'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NOP,          32'h04, 1};
      vectors[3]  = '{1'b1, 32'h2010_AAAA, 32'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NOP,          32'h04, 2};
      vectors[4]  = '{1'b1, 32'h2010_AAAA, 32'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NOP,          32'h04, 3};
      vectors[5]  = '{1'b1, 32'h2010_AAAA, 32'h08, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2010_AAAA, 32'h08, 3};
      vectors[6]  = '{1'b1, 32'h1000_FFFF, 32'h0C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_FFFF, 32'h0C, 3};
      vectors[7]  = '{1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NOP,          32'h0C, 3};
      vectors[8]  = '{1'b0, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,          32'h0C, 3};
      vectors[9]  = '{1'b1, 32'h3C01_1234, 32'h14, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3C01_1234, 32'h14, 3};
      vectors[10] = '{1'b1, 32'hAC22_0000, 32'h18, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NOP,          32'h14, 3};
      vectors[11] = '{1'b0, 32'hAC22_0000, 32'h18, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NOP,          32'h14, 3};

      bpWords[0] = '{32'h2401_0001, 32'h40};
      bpWords[1] = '{32'h2402_0002, 32'h44};
      bpWords[2] = '{32'h2403_0003, 32'h48};
      bpWords[3] = '{32'h2404_0004, 32'h4C};

      // Reset held with a word on offer: stage stays empty and refuses it
      reset = 1'b1;
      applyStimulus(1'b1, 32'h2008_0005, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int r = 0; r < 2; r++) begin
         @(posedge clock);
         #1;
         checkOutput($sformatf("reset%0d in_ready", r), 32'(inReady), 32'h0);
         checkState($sformatf("reset%0d", r), 1'b0, NOP, 32'h0, 0);
      end
      reset = 1'b0;

      // Directed table: streaming, stall bubble, flushes (out_ready mostly high)
      foreach (vectors[i]) begin
         applyStimulus(vectors[i].iv, vectors[i].instr, vectors[i].pc,
                       vectors[i].st, vectors[i].fl, vectors[i].ordy);
         #1;
         checkOutput($sformatf("vec%0d in_ready", i), 32'(inReady), 32'(vectors[i].expRdy));
         @(posedge clock);
         #1;
         checkState($sformatf("vec%0d", i), vectors[i].expValid, vectors[i].expInstr,
                    vectors[i].expPc, vectors[i].expCount);
      end

      // Back-pressure: out_ready low for two cycles under a continuous stream
      begin
         int  wi;
         logic sampledRdy;
         wi = 0;
         for (int c = 0; c < 7; c++) begin
            applyStimulus((c < 6), bpWords[wi].instr, bpWords[wi].pc, 1'b0, 1'b0, bpOrdy[c] != 0);
            #1;
            checkOutput($sformatf("bp%0d in_ready", c), 32'(inReady), 32'(bpRdy[c]));
            sampledRdy = inReady;
            @(posedge clock);
            #1;
            if ((c < 6) && sampledRdy && (wi < 3)) begin
               wi++;
            end
            checkState($sformatf("bp%0d", c), bpValid[c] != 0,
                       (bpValid[c] != 0) ? bpWords[bpOutIdx[c]].instr : NOP,
                       bpWords[bpOutIdx[c]].pc, bpCnt[c]);
         end
      end

      // Randomized traffic against the queue model
      doReset();
      modelQ.delete();
      modelLastPc = 32'h0;
      modelCount  = 0;
      for (int n = 0; n < 400; n++) begin
         randomCycle(n);
      end

      // Asynchronous reset between clock edges takes effect immediately
      applyStimulus(1'b1, 32'h1234_5678, 32'h100, 1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async reset in_ready", 32'(inReady), 32'h0);
      checkState("async reset", 1'b0, NOP, 32'h0, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Stall counter saturation: 2^CNT_W + 5 stalled cycles
      applyStimulus(1'b1, 32'h2008_0005, 32'h0, 1'b1, 1'b0, 1'b1);
      for (int s = 0; s < (1 << CNT_W) + 5; s++) begin
         @(posedge clock);
         #1;
         checkOutput($sformatf("sat%0d stall_count", s), 32'(stallCount),
                     32'(((s + 1) > CNT_MAX) ? CNT_MAX : (s + 1)));
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
